// File: rtl/cute_lock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cute_lock_pkg
// Description : Shared types, default sizes and counter helper for the
//               Cute-Lock key sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package cute_lock_pkg;

    localparam int LOCK_KEY_WIDTH  = 4;
    localparam int LOCK_NUM_STATES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ARM  = 2'd2,
        RUN  = 2'd3
    } seq_state_e;

    function automatic int next_cnt(input int cnt, input int num_states);
        return (cnt + 1 >= num_states) ? 0 : cnt + 1;
    endfunction

endpackage : cute_lock_pkg
`default_nettype wire

// File: rtl/cute_lock_key_slots.sv
`default_nettype none
// ============================================================================
// Module      : cute_lock_key_slots
// Description : NUM_STATES x KEY_WIDTH key register file with one write port,
//               synchronous zeroise, async reset and a read mux.
// Revision    : 1.0 - initial release
// ============================================================================
module cute_lock_key_slots #(
    parameter int KEY_WIDTH  = 4,
    parameter int NUM_STATES = 4,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 zeroise,
    input  logic                 wr_en,
    input  logic [CNT_WIDTH-1:0] wr_addr,
    input  logic [KEY_WIDTH-1:0] wr_data,
    input  logic [CNT_WIDTH-1:0] rd_addr,
    output logic [KEY_WIDTH-1:0] rd_data
);

    logic [KEY_WIDTH-1:0] r_mem [NUM_STATES];

    for (genvar i = 0; i < NUM_STATES; i++) begin : g_slot
        // Zeroise wins over a coincident write so an aborted load leaves nothing behind.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_mem[i] <= '0;
            end else if (zeroise) begin
                r_mem[i] <= '0;
            end else if (wr_en && (wr_addr == CNT_WIDTH'(i))) begin
                r_mem[i] <= wr_data;
            end
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule : cute_lock_key_slots
`default_nettype wire

// File: rtl/cute_lock_key_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cute_lock_key_sequencer
// Description : Loads a per-state key schedule and streams it to a Cute-Lock
//               core in lock-step with the core's 2-bit state counter.
// Revision    : 1.0 - initial release
// ============================================================================
module cute_lock_key_sequencer
    import cute_lock_pkg::*;
#(
    parameter int KEY_WIDTH  = LOCK_KEY_WIDTH,
    parameter int NUM_STATES = LOCK_NUM_STATES,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 load_valid,
    input  logic [KEY_WIDTH-1:0] load_data,
    output logic                 load_ready,
    input  logic                 start,
    input  logic                 clear,
    output logic [KEY_WIDTH-1:0] keyinput,
    output logic                 key_valid,
    output logic [CNT_WIDTH-1:0] seq_state,
    output logic                 armed
);

    localparam logic [CNT_WIDTH-1:0] c_LAST_SLOT = CNT_WIDTH'(NUM_STATES - 1);

    seq_state_e           r_state;
    seq_state_e           w_state_nxt;
    logic [CNT_WIDTH-1:0] r_ptr;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic [CNT_WIDTH-1:0] w_rd_addr;
    logic [KEY_WIDTH-1:0] r_key;
    logic [KEY_WIDTH-1:0] w_rd_data;
    logic                 w_beat;

    assign w_beat    = load_valid && (r_state == LOAD) && !clear;
    assign w_cnt_nxt = CNT_WIDTH'(next_cnt(32'(r_cnt), NUM_STATES));
    // Prefetch the word for the counter value that will be current after this edge.
    assign w_rd_addr = (r_state == RUN) ? w_cnt_nxt : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = LOAD;
                LOAD:    if (w_beat && (r_ptr == c_LAST_SLOT)) w_state_nxt = ARM;
                ARM:     if (start) w_state_nxt = RUN;
                RUN:     w_state_nxt = RUN;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
            r_cnt <= '0;
            r_key <= '0;
        end else if (clear) begin
            r_ptr <= '0;
            r_cnt <= '0;
            r_key <= '0;
        end else begin
            if (w_beat) begin
                r_ptr <= r_ptr + 1'b1;
            end
            if (w_state_nxt == RUN) begin
                r_key <= w_rd_data;
                r_cnt <= (r_state == RUN) ? w_cnt_nxt : '0;
            end else begin
                r_key <= '0;
                r_cnt <= '0;
            end
        end
    end

    cute_lock_key_slots #(
        .KEY_WIDTH  (KEY_WIDTH),
        .NUM_STATES (NUM_STATES),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_slots (
        .clock   (clock),
        .reset_n (reset_n),
        .zeroise (clear),
        .wr_en   (w_beat),
        .wr_addr (r_ptr),
        .wr_data (load_data),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_data)
    );

    assign load_ready = (r_state == LOAD);
    assign armed      = (r_state == ARM);
    assign key_valid  = (r_state == RUN);
    assign keyinput   = r_key;
    assign seq_state  = r_cnt;

endmodule : cute_lock_key_sequencer
`default_nettype wire

// File: tb/tb_cute_lock_key_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cute_lock_key_sequencer
// Description : Directed self-checking bench for cute_lock_key_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cute_lock_key_sequencer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       load_valid;
    logic [3:0] load_data;
    logic       load_ready;
    logic       start;
    logic       clear;
    logic [3:0] keyinput;
    logic       key_valid;
    logic [1:0] seq_state;
    logic       armed;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    cute_lock_key_sequencer #(
        .KEY_WIDTH  (4),
        .NUM_STATES (4),
        .CNT_WIDTH  (2)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .start      (start),
        .clear      (clear),
        .keyinput   (keyinput),
        .key_valid  (key_valid),
        .seq_state  (seq_state),
        .armed      (armed)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expect the idle-side outputs (no stream, counter parked at 0).
    task automatic check_quiet(input string tag, input logic exp_armed, input logic exp_ready);
        check({tag, ".key_valid"}, 32'(key_valid), 32'(1'b0));
        check({tag, ".keyinput"},  32'(keyinput),  32'h0);
        check({tag, ".seq_state"}, 32'(seq_state), 32'h0);
        check({tag, ".armed"},     32'(armed),     32'(exp_armed));
        check({tag, ".load_ready"},32'(load_ready),32'(exp_ready));
    endtask

    task automatic load4(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        logic [3:0] w [4];
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_data  = w[i];
            tick();
        end
        load_valid = 1'b0;
        load_data  = 4'h0;
    endtask

    // Pulse start in ARM and check n stream cycles against a 4-entry schedule.
    task automatic run_stream(input string tag, input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d, input int n);
        logic [3:0] w [4];
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s.kv%0d", tag, i),  32'(key_valid), 32'(1'b1));
            check($sformatf("%s.seq%0d", tag, i), 32'(seq_state), 32'(i % 4));
            check($sformatf("%s.key%0d", tag, i), 32'(keyinput),  32'(w[i % 4]));
            if (i != n - 1) tick();
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        load_valid = 1'b0;
        load_data  = 4'h0;
        start      = 1'b0;
        clear      = 1'b0;
        #2;
        check_quiet("reset", 1'b0, 1'b0);
        tick();
        reset_n = 1'b1;
        check_quiet("idle", 1'b0, 1'b0);

        // 1: back-to-back load, stream wraps with no gap
        tick();
        check_quiet("load_entry", 1'b0, 1'b1);
        load4(4'h9, 4'h1, 4'hE, 4'hA);
        check_quiet("t1_armed", 1'b1, 1'b0);
        run_stream("t1", 4'h9, 4'h1, 4'hE, 4'hA, 6);

        // 2: load_valid toggling, only accepted beats count
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) begin
            logic [3:0] v [4];
            v[0] = 4'h9; v[1] = 4'h1; v[2] = 4'hE; v[3] = 4'hA;
            load_valid = (i % 2 == 0);
            load_data  = (i % 2 == 0) ? v[i / 2] : 4'hF;
            tick();
            check($sformatf("t2.armed%0d", i), 32'(armed), 32'(i == 6));
        end
        load_valid = 1'b0;
        run_stream("t2", 4'h9, 4'h1, 4'hE, 4'hA, 5);

        // 3: start during LOAD is ignored; ARM holds without start
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        load_valid = 1'b1; load_data = 4'h5; tick();
        load_data = 4'h6; tick();
        load_valid = 1'b0; start = 1'b1; tick();
        start = 1'b0;
        check_quiet("t3_mid", 1'b0, 1'b1);
        load_valid = 1'b1; load_data = 4'h7; tick();
        load_data = 4'h8; tick();
        load_valid = 1'b0;
        tick();
        tick();
        check_quiet("t3_hold", 1'b1, 1'b0);

        // 4: clear at seq_state=2 during RUN, then reload constant schedule
        run_stream("t4pre", 4'h5, 4'h6, 4'h7, 4'h8, 3);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_quiet("t4_clr", 1'b0, 1'b0);
        tick();
        load4(4'h3, 4'h3, 4'h3, 4'h3);
        run_stream("t4", 4'h3, 4'h3, 4'h3, 4'h3, 4);

        // 5: clear with the 4th beat discards it; pointer restarts at 0
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        load_valid = 1'b1;
        load_data = 4'h1; tick();
        load_data = 4'h2; tick();
        load_data = 4'h4; tick();
        load_data = 4'h8; clear = 1'b1; tick();
        clear = 1'b0; load_valid = 1'b0; start = 1'b1;
        check_quiet("t5_clr", 1'b0, 1'b0);
        tick();
        check_quiet("t5_load", 1'b0, 1'b1);
        tick();
        start = 1'b0;
        check_quiet("t5_nostart", 1'b0, 1'b1);
        load_valid = 1'b1;
        load_data = 4'hC; tick();
        load_data = 4'hD; tick();
        load_data = 4'hE; tick();
        check("t5.armed3", 32'(armed), 32'(1'b0));
        load_data = 4'hF; tick();
        load_valid = 1'b0;
        check("t5.armed4", 32'(armed), 32'(1'b1));
        run_stream("t5", 4'hC, 4'hD, 4'hE, 4'hF, 5);

        // 6: async reset mid-RUN, then start ignored in IDLE/LOAD
        #2;
        reset_n = 1'b0;
        #1;
        check_quiet("t6_async", 1'b0, 1'b0);
        #1;
        reset_n = 1'b1;
        start = 1'b1;
        tick();
        check_quiet("t6_idle", 1'b0, 1'b1);
        tick();
        check_quiet("t6_load", 1'b0, 1'b1);
        start = 1'b0;
        load4(4'h1, 4'h2, 4'h3, 4'h4);
        // load_valid in ARM must not write any slot
        load_valid = 1'b1;
        load_data  = 4'hF;
        tick();
        tick();
        load_valid = 1'b0;
        check_quiet("t6_arm", 1'b1, 1'b0);
        run_stream("t6", 4'h1, 4'h2, 4'h3, 4'h4, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_cute_lock_key_sequencer
`default_nettype wire
